// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stop flags, stall codes, FSM states, address width.
package pipe_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int          INST_ADDR_W = 32;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    // Bit order WB, MEM, EX, ID, IF, PC; a stage stall also holds every stage before it.
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
    localparam logic [5:0] STALL_EX   = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};
    localparam logic [5:0] STALL_MEM  = {NO_STOP, STOP, STOP, STOP, STOP, STOP};
    localparam logic [5:0] STALL_ALL  = {6{STOP}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EXC_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    function automatic logic [5:0] stall_code(input logic id, input logic ex, input logic mem);
        if (mem)
            return STALL_MEM;
        else if (ex)
            return STALL_EX;
        else if (id)
            return STALL_ID;
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: counts consecutive enabled cycles and pulses timeout on the TIMEOUT-th one.
module pipe_ctrl_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clr,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_reg;

    assign timeout = count_en && !clr && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else if (clr || timeout)
            cnt_reg <= '0;
        else if (count_en)
            cnt_reg <= cnt_reg + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with exception redirect.
// Optional stall watchdog compiled in with PIPE_CTRL_WDOG_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          STALL_TIMEOUT = 1024,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   excp_req,
    input  logic [INST_ADDR_W-1:0] excp_pc,
    output logic [5:0]             stall,
    output logic                   flush,
    output logic [INST_ADDR_W-1:0] new_pc,
    output logic                   wdog_to
);

    state_e                 state_reg, state_next;
    logic [INST_ADDR_W-1:0] epc_reg, epc_next;
    logic [INST_ADDR_W-1:0] new_pc_reg, redirect_pc;
    logic                   flush_reg;
    logic [5:0]             req_stall, stall_c;
    logic                   count_en, timeout;

    assign req_stall = stall_code(stallreq_id, stallreq_ex, stallreq_mem);
    // Only plain request-driven stalls in RUN age the watchdog; an accepted exception resets it.
    assign count_en  = rst && (state_reg == ST_RUN) && !excp_req && (req_stall != STALL_NONE);

`ifdef PIPE_CTRL_WDOG_EN
    pipe_ctrl_wdog #(
        .TIMEOUT (STALL_TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .count_en (count_en),
        .clr      (!count_en),
        .timeout  (timeout)
    );
`else
    logic unused_wdog;
    assign unused_wdog = count_en ^ (STALL_TIMEOUT == 0);
    assign timeout     = 1'b0;
`endif

    assign wdog_to = timeout;

    always_comb begin
        state_next  = state_reg;
        stall_c     = STALL_NONE;
        epc_next    = epc_reg;
        redirect_pc = epc_reg;
        case (state_reg)
            ST_RUN: begin
                if (excp_req) begin
                    epc_next    = excp_pc;
                    redirect_pc = excp_pc;
                    stall_c     = STALL_ALL;
                    state_next  = stallreq_mem ? ST_EXC_WAIT : ST_FLUSH;
                end else begin
                    stall_c = req_stall;
                    if (timeout) begin
                        redirect_pc = RESET_PC;
                        state_next  = ST_FLUSH;
                    end
                end
            end
            ST_EXC_WAIT: begin
                stall_c = STALL_ALL;
                if (!stallreq_mem)
                    state_next = ST_FLUSH;
            end
            ST_FLUSH: state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    assign stall  = rst ? stall_c : STALL_NONE;
    assign flush  = flush_reg;
    assign new_pc = new_pc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_RUN;
            epc_reg    <= RESET_PC;
            flush_reg  <= 1'b0;
            new_pc_reg <= RESET_PC;
        end else begin
            state_reg <= state_next;
            epc_reg   <= epc_next;
            flush_reg <= (state_next == ST_FLUSH);
            if (state_next == ST_FLUSH)
                new_pc_reg <= redirect_pc;
        end
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter STALL_TIMEOUT, default 1024: consecutive stall cycles before watchdog fires (used only with the watchdog compiled in).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: new_pc value out of reset.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port stallreq_id, input, 1: ID hazard request (load-use).
REQ-006 The block SHALL have port stallreq_ex, input, 1: EX multi-cycle operation busy.
REQ-007 The block SHALL have port stallreq_mem, input, 1: MEM data-bus wait.
REQ-008 The block SHALL have port excp_req, input, 1: MEM stage reports an exception.
REQ-009 The block SHALL have port excp_pc, input, 32: handler address accompanying excp_req.
REQ-010 The block SHALL have port stall, output, 6: per-stage hold, bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-011 The block SHALL have port flush, output, 1: clears all pipeline registers for one cycle.
REQ-012 The block SHALL have port new_pc, output, 32: redirect target, valid while flush=1.
REQ-013 The block SHALL have port wdog_to, output, 1: one-cycle watchdog pulse (tied 0 without the watchdog).

Function
REQ-014 stall SHALL be combinational from the requests and the state, in the same cycle; flush and new_pc SHALL be registered.
REQ-015 In RUN with no exception accepted, stall SHALL follow priority mem > ex > id: stallreq_mem gives 6'b011111, else stallreq_ex gives 6'b001111, else stallreq_id gives 6'b000111, else 6'b000000.
REQ-016 The FSM SHALL have three states: RUN, EXC_WAIT and FLUSH.
REQ-017 In RUN, excp_req=1 with stallreq_mem=0 SHALL latch excp_pc, drive stall=6'b111111 in that cycle, and go to FLUSH.
REQ-018 In RUN, excp_req=1 with stallreq_mem=1 SHALL latch excp_pc and go to EXC_WAIT.
REQ-019 In EXC_WAIT, stall SHALL be 6'b111111 and excp_req SHALL be ignored.
REQ-020 EXC_WAIT SHALL go to FLUSH in the first cycle in which stallreq_mem=0.
REQ-021 In FLUSH, flush SHALL be 1, new_pc SHALL be the latched address and stall SHALL be 6'b000000.
REQ-022 In FLUSH, all requests SHALL be ignored, and the FSM SHALL return to RUN after exactly 1 cycle.
REQ-023 Latency from exception acceptance to flush SHALL be 1 cycle.
REQ-024 Outside FLUSH, flush SHALL be 0 and new_pc SHALL hold its last value.
REQ-025 If excp_req and any stall request are simultaneous in RUN, the exception SHALL win per REQ-017/REQ-018.
REQ-026 excp_req arriving in the FLUSH cycle SHALL be dropped; the MEM stage is being cleared.

Reset
REQ-027 Reset assertion (rst=0) SHALL immediately set state=RUN, flush=0, new_pc=RESET_PC, wdog_to=0, watchdog count=0 and the latched pc=RESET_PC.
REQ-028 While in reset, stall SHALL be 6'b000000.
REQ-029 Reset during EXC_WAIT or FLUSH SHALL abandon the pending redirect; no flush SHALL follow release.
REQ-030 Release SHALL be synchronised externally; the block SHALL resume in RUN on the first edge after release.

Configuration
REQ-031 When PIPE_CTRL_WDOG_EN is defined, a counter SHALL increment on every cycle with stall!=0 in RUN and clear on any cycle with stall=0 or any non-RUN state.
REQ-032 When the count reaches STALL_TIMEOUT-1 with the stall still present, wdog_to SHALL pulse for 1 cycle, the FSM SHALL enter FLUSH with new_pc=RESET_PC, and the counter SHALL clear.
REQ-033 When PIPE_CTRL_WDOG_EN is undefined, wdog_to SHALL be constant 0, no counter logic SHALL exist, and a stall SHALL persist indefinitely.

Structure
REQ-034 The shared defines file SHALL hold: `Stop/`NoStop, the stall codes (STALL_NONE/ID/EX/MEM/ALL), the FSM state encodings, `InstAddrBus and `ZeroWord.
REQ-035 The watchdog SHALL be one sub-module, pipe_ctrl_wdog (clk, rst, count_en, clr, timeout), instantiated only under PIPE_CTRL_WDOG_EN.

Verification
REQ-036 stallreq_id=1 and stallreq_ex=1 for 3 cycles -> stall=6'b001111 each cycle, flush=0.
REQ-037 excp_req=1 with excp_pc=32'h0000_0180 and no stall -> stall=6'b111111 that cycle; next cycle flush=1, new_pc=32'h0000_0180, stall=0; the cycle after, flush=0.
REQ-038 excp_req=1 while stallreq_mem=1 for 4 more cycles -> stall=6'b111111 for 4 cycles; flush=1 in the cycle after stallreq_mem drops.
REQ-039 rst=0 asserted mid-EXC_WAIT, then released -> no flush ever, stall=0, new_pc=RESET_PC.
REQ-040 With PIPE_CTRL_WDOG_EN and STALL_TIMEOUT=8, stallreq_ex held high -> wdog_to pulses in the 8th stall cycle; next cycle flush=1, new_pc=RESET_PC.
REQ-041 excp_req=1 during the FLUSH cycle -> ignored; the FSM returns to RUN and no second flush occurs.
